// File: rtl/video_dnn_argmax_hist.sv
// Per-pixel popcount argmax over binary DNN votes, with a reject code for low-confidence pixels.
// Define VIDEO_DNN_ARGMAX_HIST_EN to build the per-frame class histogram; otherwise its outputs are tied to 0.
module video_dnn_argmax_hist #(
    parameter int NUM_CLASS     = 10,
    parameter int CHANNEL_WIDTH = 8,
    parameter int TUSER_WIDTH   = 1,
    parameter int TDATA_WIDTH   = CHANNEL_WIDTH * NUM_CLASS,
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4,
    parameter int HIST_WIDTH    = 20
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [TCOUNT_WIDTH-1:0]              param_threshold,
    input  logic [TUSER_WIDTH-1:0]               s_axi4s_tuser,
    input  logic                                 s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]               s_axi4s_tdata,
    input  logic                                 s_axi4s_tvalid,
    output logic                                 s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]               m_axi4s_tuser,
    output logic                                 m_axi4s_tlast,
    output logic [TNUMBER_WIDTH-1:0]             m_axi4s_tnumber,
    output logic [TCOUNT_WIDTH-1:0]              m_axi4s_tcount,
    output logic [TDATA_WIDTH-1:0]               m_axi4s_tdata,
    output logic                                 m_axi4s_tvalid,
    input  logic                                 m_axi4s_tready,
    output logic [(NUM_CLASS+1)*HIST_WIDTH-1:0]  m_hist_data,
    output logic                                 m_hist_valid
);
    localparam int LEVELS = $clog2(NUM_CLASS);

    // Operands alive at a given tree level; an odd count leaves one pass-through operand.
    function automatic int level_size(input int lvl);
        int n;
        n = NUM_CLASS;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    logic cke;
    assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
    assign s_axi4s_tready = cke;

    logic [TCOUNT_WIDTH-1:0]  pop_cnt    [NUM_CLASS];
    logic [TCOUNT_WIDTH-1:0]  tree_cnt   [LEVELS+1][NUM_CLASS];
    logic [TNUMBER_WIDTH-1:0] tree_idx   [LEVELS+1][NUM_CLASS];
    logic [TCOUNT_WIDTH-1:0]  tree_cnt_d [LEVELS][NUM_CLASS];
    logic [TNUMBER_WIDTH-1:0] tree_idx_d [LEVELS][NUM_CLASS];

    logic [LEVELS:0]          pipe_valid;
    logic [TUSER_WIDTH-1:0]   pipe_tuser [LEVELS+1];
    logic                     pipe_tlast [LEVELS+1];
    logic [TDATA_WIDTH-1:0]   pipe_tdata [LEVELS+1];

    always_comb begin
        for (int i = 0; i < NUM_CLASS; i++) begin
            pop_cnt[i] = '0;
            for (int j = 0; j < CHANNEL_WIDTH; j++) begin
                pop_cnt[i] = pop_cnt[i] + TCOUNT_WIDTH'(s_axi4s_tdata[j*NUM_CLASS + i]);
            end
        end
    end

    // Lower index sits in the even slot, so strict greater-than keeps ties on the lower class.
    always_comb begin
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                tree_cnt_d[l][k] = '0;
                tree_idx_d[l][k] = '0;
            end
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < (NUM_CLASS + 1) / 2; k++) begin
                if (2*k + 1 < level_size(l)) begin
                    if (tree_cnt[l][2*k+1] > tree_cnt[l][2*k]) begin
                        tree_cnt_d[l][k] = tree_cnt[l][2*k+1];
                        tree_idx_d[l][k] = tree_idx[l][2*k+1];
                    end else begin
                        tree_cnt_d[l][k] = tree_cnt[l][2*k];
                        tree_idx_d[l][k] = tree_idx[l][2*k];
                    end
                end else if (2*k < level_size(l)) begin
                    tree_cnt_d[l][k] = tree_cnt[l][2*k];
                    tree_idx_d[l][k] = tree_idx[l][2*k];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_valid <= '0;
            for (int s = 0; s <= LEVELS; s++) begin
                pipe_tuser[s] <= '0;
                pipe_tlast[s] <= 1'b0;
                pipe_tdata[s] <= '0;
                for (int k = 0; k < NUM_CLASS; k++) begin
                    tree_cnt[s][k] <= '0;
                    tree_idx[s][k] <= '0;
                end
            end
        end else if (cke) begin
            pipe_valid    <= {pipe_valid[LEVELS-1:0], s_axi4s_tvalid};
            pipe_tuser[0] <= s_axi4s_tuser;
            pipe_tlast[0] <= s_axi4s_tlast;
            pipe_tdata[0] <= s_axi4s_tdata;
            for (int k = 0; k < NUM_CLASS; k++) begin
                tree_cnt[0][k] <= pop_cnt[k];
                tree_idx[0][k] <= TNUMBER_WIDTH'(k);
            end
            for (int s = 1; s <= LEVELS; s++) begin
                pipe_tuser[s] <= pipe_tuser[s-1];
                pipe_tlast[s] <= pipe_tlast[s-1];
                pipe_tdata[s] <= pipe_tdata[s-1];
                for (int k = 0; k < NUM_CLASS; k++) begin
                    tree_cnt[s][k] <= tree_cnt_d[s-1][k];
                    tree_idx[s][k] <= tree_idx_d[s-1][k];
                end
            end
        end
    end

    // Threshold is sampled here, at the final stage, so a change applies to whatever pixel is arriving.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi4s_tvalid  <= 1'b0;
            m_axi4s_tuser   <= '0;
            m_axi4s_tlast   <= 1'b0;
            m_axi4s_tdata   <= '0;
            m_axi4s_tcount  <= '0;
            m_axi4s_tnumber <= '0;
        end else if (cke) begin
            m_axi4s_tvalid  <= pipe_valid[LEVELS];
            m_axi4s_tuser   <= pipe_tuser[LEVELS];
            m_axi4s_tlast   <= pipe_tlast[LEVELS];
            m_axi4s_tdata   <= pipe_tdata[LEVELS];
            m_axi4s_tcount  <= tree_cnt[LEVELS][0];
            m_axi4s_tnumber <= (tree_cnt[LEVELS][0] < param_threshold) ?
                               TNUMBER_WIDTH'(NUM_CLASS) : tree_idx[LEVELS][0];
        end
    end

`ifdef VIDEO_DNN_ARGMAX_HIST_EN
    logic [HIST_WIDTH-1:0] bins [NUM_CLASS+1];
    logic                  hist_active;
    logic                  out_hs;
    logic                  out_sof;

    assign out_hs  = m_axi4s_tvalid && m_axi4s_tready;
    assign out_sof = out_hs && m_axi4s_tuser[0];

    // Frame start publishes the finished frame (if one was being counted) and restarts with this beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hist_active  <= 1'b0;
            m_hist_valid <= 1'b0;
            m_hist_data  <= '0;
            for (int k = 0; k <= NUM_CLASS; k++) begin
                bins[k] <= '0;
            end
        end else begin
            m_hist_valid <= 1'b0;
            if (out_sof) begin
                hist_active <= 1'b1;
                if (hist_active) begin
                    m_hist_valid <= 1'b1;
                    for (int k = 0; k <= NUM_CLASS; k++) begin
                        m_hist_data[k*HIST_WIDTH +: HIST_WIDTH] <= bins[k];
                    end
                end
                for (int k = 0; k <= NUM_CLASS; k++) begin
                    bins[k] <= (TNUMBER_WIDTH'(k) == m_axi4s_tnumber) ? HIST_WIDTH'(1) : '0;
                end
            end else if (out_hs) begin
                for (int k = 0; k <= NUM_CLASS; k++) begin
                    if (TNUMBER_WIDTH'(k) == m_axi4s_tnumber && bins[k] != '1) begin
                        bins[k] <= bins[k] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign m_hist_data  = '0;
    assign m_hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_dnn_argmax_hist.sv
// Randomized bench for video_dnn_argmax_hist against a queue-based argmax/histogram reference model.
// Histogram expectations follow VIDEO_DNN_ARGMAX_HIST_EN as defined for the build.
`timescale 1ns/1ps
module tb_video_dnn_argmax_hist;
    localparam int NC   = 10;
    localparam int CW   = 8;
    localparam int UW   = 1;
    localparam int DW   = CW * NC;
    localparam int NW   = 4;
    localparam int CNTW = 4;
    localparam int HW   = 20;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic [CNTW-1:0]       param_threshold;
    logic [UW-1:0]         s_axi4s_tuser;
    logic                  s_axi4s_tlast;
    logic [DW-1:0]         s_axi4s_tdata;
    logic                  s_axi4s_tvalid;
    logic                  s_axi4s_tready;
    logic [UW-1:0]         m_axi4s_tuser;
    logic                  m_axi4s_tlast;
    logic [NW-1:0]         m_axi4s_tnumber;
    logic [CNTW-1:0]       m_axi4s_tcount;
    logic [DW-1:0]         m_axi4s_tdata;
    logic                  m_axi4s_tvalid;
    logic                  m_axi4s_tready;
    logic [(NC+1)*HW-1:0]  m_hist_data;
    logic                  m_hist_valid;

    always #5 aclk = ~aclk;

    video_dnn_argmax_hist #(
        .NUM_CLASS(NC), .CHANNEL_WIDTH(CW), .TUSER_WIDTH(UW), .TDATA_WIDTH(DW),
        .TNUMBER_WIDTH(NW), .TCOUNT_WIDTH(CNTW), .HIST_WIDTH(HW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .param_threshold(param_threshold),
        .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
        .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
        .s_axi4s_tready(s_axi4s_tready),
        .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
        .m_axi4s_tnumber(m_axi4s_tnumber), .m_axi4s_tcount(m_axi4s_tcount),
        .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
        .m_axi4s_tready(m_axi4s_tready),
        .m_hist_data(m_hist_data), .m_hist_valid(m_hist_valid)
    );

    typedef struct packed {
        logic          tuser;
        logic          tlast;
        logic [DW-1:0] tdata;
        logic [NW-1:0] num;
        logic [CNTW-1:0] cnt;
    } px_t;

    px_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Argmax straight from the definition: first class reaching the highest vote count.
    function automatic px_t model_px(input logic tu, input logic tl, input logic [DW-1:0] d, input int th);
        int   cnt[NC];
        int   best;
        px_t  r;
        for (int i = 0; i < NC; i++) begin
            cnt[i] = 0;
            for (int j = 0; j < CW; j++) cnt[i] += int'(d[j*NC + i]);
        end
        best = 0;
        for (int i = 1; i < NC; i++) if (cnt[i] > cnt[best]) best = i;
        r.tuser = tu;
        r.tlast = tl;
        r.tdata = d;
        r.cnt   = CNTW'(cnt[best]);
        r.num   = (cnt[best] < th) ? NW'(NC) : NW'(best);
        return r;
    endfunction

    function automatic logic [DW-1:0] votes_for(input int c[NC]);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++)
            for (int j = 0; j < CW; j++) v[j*NC + i] = (j < c[i]);
        return v;
    endfunction

    // Reference histogram and output monitor, sampled on the falling edge.
    int              hbins [NC+1];
    logic [HW-1:0]   hsnap [NC+1];
    bit              hactive, hpending, exp_pulse, stalled;
    int              n_pulse = 0;
    logic [127:0]    stall_snap;
    px_t             e;

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            for (int k = 0; k <= NC; k++) hbins[k] = 0;
            hactive  = 0;
            hpending = 0;
            stalled  = 0;
        end else begin
            exp_pulse = hpending;
            hpending  = 0;
            if (m_hist_valid) n_pulse++;
`ifdef VIDEO_DNN_ARGMAX_HIST_EN
            if (exp_pulse || m_hist_valid) begin
                check_val("hist_valid", m_hist_valid, exp_pulse);
                if (exp_pulse)
                    for (int k = 0; k <= NC; k++)
                        check_val($sformatf("hist_bin%0d", k), m_hist_data[k*HW +: HW], hsnap[k]);
            end
`else
            if (m_hist_valid || m_hist_data != '0)
                check_val("hist_tied", {m_hist_valid, m_hist_data}, '0);
`endif
            if (stalled)
                check_val("stall_hold", {m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber,
                                         m_axi4s_tcount, m_axi4s_tdata}, stall_snap);
            check_val("s_tready", s_axi4s_tready, !m_axi4s_tvalid || m_axi4s_tready);
            if (s_axi4s_tvalid && s_axi4s_tready)
                exp_q.push_back(model_px(s_axi4s_tuser[0], s_axi4s_tlast, s_axi4s_tdata, int'(param_threshold)));
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("tnumber", m_axi4s_tnumber, e.num);
                    check_val("tcount",  m_axi4s_tcount,  e.cnt);
                    check_val("tdata",   m_axi4s_tdata,   e.tdata);
                    check_val("tuser",   m_axi4s_tuser,   e.tuser);
                    check_val("tlast",   m_axi4s_tlast,   e.tlast);
                    if (e.tuser) begin
                        if (hactive) begin
                            for (int k = 0; k <= NC; k++) hsnap[k] = HW'(hbins[k]);
                            hpending = 1;
                        end
                        for (int k = 0; k <= NC; k++) hbins[k] = 0;
                        hbins[e.num] = 1;
                        hactive = 1;
                    end else if (hbins[e.num] < (1 << HW) - 1) begin
                        hbins[e.num]++;
                    end
                end
            end
            stalled = m_axi4s_tvalid && !m_axi4s_tready;
            if (stalled)
                stall_snap = {m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber,
                              m_axi4s_tcount, m_axi4s_tdata};
        end
    end

    bit rnd_ready = 0;
    initial begin
        m_axi4s_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_axi4s_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic tu, input logic tl, input logic [DW-1:0] d);
        int waited = 0;
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tuser  = UW'(tu);
        s_axi4s_tlast  = tl;
        s_axi4s_tdata  = d;
        forever begin
            @(negedge aclk);
            if (s_axi4s_tready) break;
            waited++;
            if (waited > 200) begin
                check_val("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_axi4s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 1000) begin
            @(posedge aclk);
            #1;
            waited++;
        end
        if (waited >= 1000) check_val("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic run_pixel(input logic [DW-1:0] d, output int lat, output logic [NW-1:0] num,
                             output logic [CNTW-1:0] cnt, output logic [DW-1:0] dout);
        @(posedge aclk);
        #1;
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tuser  = '0;
        s_axi4s_tlast  = 1'b0;
        s_axi4s_tdata  = d;
        @(posedge aclk);
        #1;
        s_axi4s_tvalid = 1'b0;
        lat = 1;
        while (!m_axi4s_tvalid && lat < 50) begin
            @(posedge aclk);
            #1;
            lat++;
        end
        num  = m_axi4s_tnumber;
        cnt  = m_axi4s_tcount;
        dout = m_axi4s_tdata;
    endtask

    int              c [NC];
    int              lat, base_pulse, mode;
    logic [NW-1:0]   num;
    logic [CNTW-1:0] cnt;
    logic [DW-1:0]   d, dout, cls1, rej;

    initial begin
        aresetn         = 1'b0;
        param_threshold = '0;
        s_axi4s_tvalid  = 1'b0;
        s_axi4s_tuser   = '0;
        s_axi4s_tlast   = 1'b0;
        s_axi4s_tdata   = '0;
        #12;
        check_val("rst_tvalid", m_axi4s_tvalid, 0);
        check_val("rst_tnumber", m_axi4s_tnumber, 0);
        check_val("rst_hist", {m_hist_valid, m_hist_data}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Directed pixels
        for (int i = 0; i < NC; i++) c[i] = 0;
        c[3] = 8;
        d = votes_for(c);
        run_pixel(d, lat, num, cnt, dout);
        check_val("cls3_latency", lat, 6);
        check_val("cls3_num", num, 3);
        check_val("cls3_cnt", cnt, 8);
        check_val("cls3_tdata", dout, d);

        for (int i = 0; i < NC; i++) c[i] = 1;
        c[2] = 5;
        c[7] = 5;
        d = votes_for(c);
        run_pixel(d, lat, num, cnt, dout);
        check_val("tie_num", num, 2);
        check_val("tie_cnt", cnt, 5);
        param_threshold = 4'd6;
        run_pixel(d, lat, num, cnt, dout);
        check_val("thr6_num", num, NC);
        check_val("thr6_cnt", cnt, 5);
        param_threshold = 4'd5;
        run_pixel(d, lat, num, cnt, dout);
        check_val("thr5_num", num, 2);

        param_threshold = '0;
        for (int i = 0; i < NC; i++) c[i] = 2;
        c[NC-1] = 7;
        run_pixel(votes_for(c), lat, num, cnt, dout);
        check_val("last_cls_num", num, NC - 1);
        for (int i = 0; i < NC; i++) c[i] = 0;
        run_pixel(votes_for(c), lat, num, cnt, dout);
        check_val("zero_num", num, 0);
        check_val("zero_cnt", cnt, 0);
        drain();

        // Random stream with random backpressure and bubbles
        rnd_ready       = 1;
        param_threshold = 4'd3;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge aclk);
                #1;
            end
            mode = $urandom_range(0, 2);
            if (mode == 0) d = DW'({$urandom, $urandom, $urandom});
            else if (mode == 1) d = DW'({$urandom, $urandom, $urandom}) & DW'({$urandom, $urandom, $urandom});
            else begin
                for (int i = 0; i < NC; i++) c[i] = $urandom_range(0, CW);
                d = votes_for(c);
            end
            send_beat((n == 0) || ($urandom_range(0, 19) == 0), $urandom_range(0, 1), d);
        end
        drain();
        rnd_ready = 0;

        // Reset in the middle of a frame
        param_threshold = '0;
        send_beat(1'b1, 1'b0, DW'({$urandom, $urandom, $urandom}));
        for (int n = 0; n < 5; n++) send_beat(1'b0, 1'b0, DW'({$urandom, $urandom, $urandom}));
        #1;
        aresetn = 1'b0;
        #1;
        check_val("midrst_tvalid", m_axi4s_tvalid, 0);
        check_val("midrst_side", {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount}, 0);
        check_val("midrst_tdata", m_axi4s_tdata, 0);
        check_val("midrst_hist", {m_hist_valid, m_hist_data}, 0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Histogram frames: 4 class-1 pixels and 2 rejects, then the next frame start
        param_threshold = 4'd3;
        for (int i = 0; i < NC; i++) c[i] = 0;
        c[1] = 8;
        cls1 = votes_for(c);
        for (int i = 0; i < NC; i++) c[i] = 1;
        rej = votes_for(c);
        base_pulse = n_pulse;
        send_beat(1'b1, 1'b0, cls1);
        for (int n = 0; n < 3; n++) send_beat(1'b0, 1'b0, cls1);
        send_beat(1'b0, 1'b0, rej);
        send_beat(1'b0, 1'b1, rej);
        drain();
        check_val("no_pulse_first_frame", n_pulse - base_pulse, 0);
        for (int i = 0; i < NC; i++) c[i] = 0;
        c[5] = 8;
        send_beat(1'b1, 1'b0, votes_for(c));
        drain();
`ifdef VIDEO_DNN_ARGMAX_HIST_EN
        check_val("frame2_pulses", n_pulse - base_pulse, 1);
        for (int k = 0; k <= NC; k++)
            check_val($sformatf("frame1_bin%0d", k), m_hist_data[k*HW +: HW],
                      (k == 1) ? 4 : ((k == NC) ? 2 : 0));
`else
        check_val("frame2_pulses", n_pulse - base_pulse, 0);
        check_val("hist_data_zero", m_hist_data, 0);
`endif
        check_val("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/video_dnn_argmax_hist.md
Name: video_dnn_argmax_hist

Overview:
- Per-pixel classifier back end for a binary DNN video stream.
- Per pixel: popcounts CHANNEL_WIDTH binary votes for each of NUM_CLASS classes and picks the argmax through a registered compare tree.
- Rejects low-confidence pixels by emitting a reserved class number.
- Sits between the DNN core and the overlay/OLED path; adds a per-frame class histogram for software.

Parameters:
- NUM_CLASS, 10, number of classes (2..64).
- CHANNEL_WIDTH, 8, votes per class.
- TUSER_WIDTH, 1, user width; bit 0 = start of frame.
- TDATA_WIDTH, CHANNEL_WIDTH*NUM_CLASS, input vote vector; bit j*NUM_CLASS+i is vote j of class i.
- TNUMBER_WIDTH, 4, class index width; must hold NUM_CLASS (the reject code).
- TCOUNT_WIDTH, 4, count width; must be >= clog2(CHANNEL_WIDTH+1).
- HIST_WIDTH, 20, histogram bin width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- param_threshold  in  TCOUNT_WIDTH  minimum winning count; quasi-static.
- s_axi4s_tuser  in  TUSER_WIDTH  user / frame start.
- s_axi4s_tlast  in  1  end of line.
- s_axi4s_tdata  in  TDATA_WIDTH  vote vector.
- s_axi4s_tvalid  in  1  input valid.
- s_axi4s_tready  out  1  input ready.
- m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser.
- m_axi4s_tlast  out  1  delayed tlast.
- m_axi4s_tnumber  out  TNUMBER_WIDTH  winning class, or NUM_CLASS on reject.
- m_axi4s_tcount  out  TCOUNT_WIDTH  winning count.
- m_axi4s_tdata  out  TDATA_WIDTH  delayed input tdata.
- m_axi4s_tvalid  out  1  output valid.
- m_axi4s_tready  in  1  output ready.
- m_hist_data  out  (NUM_CLASS+1)*HIST_WIDTH  previous-frame bins; bin k at [k*HIST_WIDTH +: HIST_WIDTH]; bin NUM_CLASS = rejects.
- m_hist_valid  out  1  one-cycle strobe when m_hist_data updates.

Behaviour:
- Reset (aresetn=0, asynchronous): all pipeline valids, m_axi4s_* outputs, m_hist_data, m_hist_valid, bins and hist_active clear to 0 immediately. A reset mid-frame discards the partial histogram.
- Pipeline enable: cke = !m_axi4s_tvalid | m_axi4s_tready; s_axi4s_tready = cke. All stages advance only on cke.
- Bubbles (tvalid=0) propagate as invalid stages. Holding m_axi4s_tready=0 freezes the outputs stable.
- Stage 1: count[i] = sum over j of tdata[j*NUM_CLASS+i]. The result is exact.
- Compare tree: L = clog2(NUM_CLASS) registered levels. Each node keeps the larger count with its index.
- Tie rule: the lower index wins. An odd leftover operand passes through the level unchanged.
- Final stage: if max count < param_threshold, tnumber = NUM_CLASS; otherwise tnumber = index. tcount is always the max count.
- Sideband: tuser, tlast and tdata travel aligned with their pixel.
- Latency: 2+L accepted-cycles (6 for NUM_CLASS=10) from input accept to m_axi4s_tvalid, given continuous tready.
- Throughput: one pixel per clock.
- Histogram counting: on each output handshake (m_axi4s_tvalid & m_axi4s_tready), bin[tnumber] is incremented, saturating at 2^HIST_WIDTH-1.
- Frame boundary (handshake beat with tuser[0]=1), in the same cycle:
  - If hist_active=1: bins are copied to m_hist_data and m_hist_valid=1 for one cycle.
  - Bins are cleared, then the current beat is counted (its bin = 1).
  - hist_active is set to 1.
- First frame after reset: produces no strobe.
- m_hist_data holds its value until the next strobe.
- param_threshold changes take effect on the pixel that reaches the final stage; there is no glitch protection.

Optional Feature:
- Macro: VIDEO_DNN_ARGMAX_HIST_EN.
- Defined: the histogram logic is as described above.
- Undefined: no bin registers are built; m_hist_data is tied 0 and m_hist_valid is tied 0. The pixel path is identical in function and latency.

Test Plan:
- NUM_CLASS=10, threshold=0: pixel with class 3 votes=0xFF, others 0 -> tnumber=3, tcount=8, 6 cycles after accept; tdata echoed unchanged.
- Tie: classes 2 and 7 both count 5, others 1 -> tnumber=2, tcount=5.
- Threshold=6: maximum count 5 -> tnumber=10, tcount=5. Threshold=5: same pixel -> tnumber=2.
- Backpressure: random m_axi4s_tready with continuous input -> output sequence matches the reference model; no loss or duplication; outputs stable while stalled.
- Histogram (macro defined): frame 1 = 4 pixels of class 1 plus 2 rejects; frame 2 starts with tuser=1 -> m_hist_valid pulses once with bin1=4, bin10=2, others 0. No pulse at the frame 1 start.
- Reset asserted mid-frame -> all outputs 0 immediately. After release, the next frame start produces no histogram strobe.
